spart_bus_ctrl: RTL and testbench

- Sequences the SPART's 8-bit register port (iocs/iorw/ioaddr/databus) on behalf of the cache-side memory-mapped IO interface.
- Replaces ad-hoc driver logic with an arbitrated controller. After reset it writes the baud divisor. It then shares the SPART bus between an internal RX-drain engine, which has priority, and host TX/status requests.
- Received bytes are buffered in a small FIFO so host polling latency cannot drop data.

---
 rtl/spart_pkg.sv | 40 ++++
 rtl/spart_rx_fifo.sv | 60 ++++++
 rtl/spart_bus_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_spart_bus_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spart_pkg.sv
// Shared constants for the SPART bus controller: register addresses, FSM encoding
// and status-word layout.
package spart_pkg;

    localparam logic [1:0] ADDR_BUF  = 2'b00;
    localparam logic [1:0] ADDR_STAT = 2'b01;
    localparam logic [1:0] ADDR_DBL  = 2'b10;
    localparam logic [1:0] ADDR_DBH  = 2'b11;

    localparam logic [2:0] CFG_LO  = 3'd0;
    localparam logic [2:0] CFG_HI  = 3'd1;
    localparam logic [2:0] IDLE    = 3'd2;
    localparam logic [2:0] RX_RD   = 3'd3;
    localparam logic [2:0] RX_GAP  = 3'd4;
    localparam logic [2:0] TX_WAIT = 3'd5;
    localparam logic [2:0] TX_WR   = 3'd6;
    localparam logic [2:0] RESP    = 3'd7;

    localparam int STAT_RX_AVAIL  = 0;
    localparam int STAT_TBR       = 1;
    localparam int STAT_OVERRUN   = 2;
    localparam int STAT_COUNT_LSB = 4;
    localparam int STAT_COUNT_W   = 3;

    function automatic logic [31:0] pack_status(
        input logic                    rx_avail,
        input logic                    tbr,
        input logic                    overrun,
        input logic [STAT_COUNT_W-1:0] count
    );
        logic [31:0] word;
        word = '0;
        word[STAT_RX_AVAIL] = rx_avail;
        word[STAT_TBR]      = tbr;
        word[STAT_OVERRUN]  = overrun;
        word[STAT_COUNT_LSB +: STAT_COUNT_W] = count;
        return word;
    endfunction

endpackage

// File: rtl/spart_rx_fifo.sv
// Small byte FIFO holding received SPART bytes until the host polls them.
// Head byte is presented combinationally so a read response can latch it directly.
module spart_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic [7:0]  push_data,
    input  logic        pop,
    output logic [7:0]  head,
    output logic        full,
    output logic        empty,
    output logic [AW:0] count
);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   count_reg;
    logic          do_push;
    logic          do_pop;

    assign full  = (count_reg == (AW+1)'(DEPTH));
    assign empty = (count_reg == '0);
    assign count = count_reg;
    assign head  = mem[rd_ptr_reg];

    // A push into a full FIFO is still legal when the head leaves in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/spart_bus_ctrl.sv
// Arbitrated sequencer for the SPART register port: programs the baud divisor after
// reset, drains received bytes into a FIFO with priority, and serves host TX/status/data.
module spart_bus_ctrl
    import spart_pkg::*;
#(
    parameter logic [27:0] BASE_ADDR = 28'h800_0000,
    parameter logic [15:0] DIVISOR   = 16'd650,
    parameter int          RX_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        io_valid,
    input  logic        io_rw,
    input  logic [27:0] mem_addr,
    input  logic [31:0] io_wr_data,
    output logic        io_ready,
    output logic [31:0] io_rd_data,
    output logic        iocs,
    output logic        iorw,
    output logic [1:0]  ioaddr,
    inout  wire  [7:0]  databus,
    input  logic        rda,
    input  logic        tbr
);

    localparam int CW = $clog2(RX_DEPTH) + 1;

    logic [2:0]  state_reg;
    logic [2:0]  state_next;
    logic        tx_pend_reg;
    logic [7:0]  tx_byte_reg;
    logic        overrun_reg;
    logic        io_ready_reg;
    logic [31:0] io_rd_data_reg;
    logic        pop_pend_reg;
    logic        clr_ovr_reg;

    logic        fifo_push;
    logic        fifo_pop;
    logic [7:0]  fifo_head;
    logic        fifo_full;
    logic        fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [31:0] count_ext;

    logic        req_data;
    logic        req_stat;
    logic        accept;
    logic        tx_accept;
    logic [31:0] resp_data;

    logic        bus_cs;
    logic        bus_rw;
    logic [1:0]  bus_addr;
    logic [7:0]  drv_data;
    logic        unused_wr_hi;

    assign unused_wr_hi = ^io_wr_data[31:8];

    spart_rx_fifo #(
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (databus),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign req_data  = (mem_addr == BASE_ADDR);
    assign req_stat  = (mem_addr == BASE_ADDR + 28'd1);
    assign accept    = (state_reg == IDLE) && !rda && io_valid;
    assign tx_accept = accept && io_rw && req_data;
    assign count_ext = 32'(fifo_count);

    assign fifo_push = (state_reg == RX_RD) && !fifo_full;
    assign fifo_pop  = (state_reg == RESP) && pop_pend_reg;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            CFG_LO:  state_next = CFG_HI;
            CFG_HI:  state_next = IDLE;
            IDLE: begin
                if (rda) begin
                    state_next = RX_RD;
                end else if (io_valid) begin
                    state_next = (io_rw && req_data) ? TX_WAIT : RESP;
                end
            end
            RX_RD:   state_next = RX_GAP;
            // A receive that preempted a waiting transmit must hand the bus back to it.
            RX_GAP:  state_next = tx_pend_reg ? TX_WAIT : IDLE;
            TX_WAIT: begin
                if (rda) begin
                    state_next = RX_RD;
                end else if (tbr) begin
                    state_next = TX_WR;
                end
            end
            TX_WR:   state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = CFG_LO;
        endcase
    end

    always_comb begin
        resp_data = '0;
        if (accept && !io_rw) begin
            if (req_data && !fifo_empty) begin
                resp_data = {24'h0, fifo_head};
            end else if (req_stat) begin
                resp_data = pack_status(!fifo_empty, tbr, overrun_reg,
                                        count_ext[STAT_COUNT_W-1:0]);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= CFG_LO;
            tx_pend_reg    <= 1'b0;
            tx_byte_reg    <= 8'h00;
            overrun_reg    <= 1'b0;
            io_ready_reg   <= 1'b0;
            io_rd_data_reg <= 32'h0;
            pop_pend_reg   <= 1'b0;
            clr_ovr_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            io_ready_reg <= (state_next == RESP);
            pop_pend_reg <= accept && !io_rw && req_data && !fifo_empty;
            clr_ovr_reg  <= accept && !io_rw && req_stat;
            if (state_next == RESP) begin
                io_rd_data_reg <= resp_data;
            end
            if (tx_accept) begin
                tx_pend_reg <= 1'b1;
                tx_byte_reg <= io_wr_data[7:0];
            end else if (state_reg == TX_WR) begin
                tx_pend_reg <= 1'b0;
            end
            // A dropped byte outranks the clear-on-read of the status register.
            if ((state_reg == RX_RD) && fifo_full) begin
                overrun_reg <= 1'b1;
            end else if ((state_reg == RESP) && clr_ovr_reg) begin
                overrun_reg <= 1'b0;
            end
        end
    end

    // Bus strobes decode the current state; holding reset keeps the port quiet.
    always_comb begin
        bus_cs   = 1'b0;
        bus_rw   = 1'b1;
        bus_addr = ADDR_BUF;
        drv_data = 8'h00;
        if (!rst) begin
            case (state_reg)
                CFG_LO: begin
                    bus_cs   = 1'b1;
                    bus_rw   = 1'b0;
                    bus_addr = ADDR_DBL;
                    drv_data = DIVISOR[7:0];
                end
                CFG_HI: begin
                    bus_cs   = 1'b1;
                    bus_rw   = 1'b0;
                    bus_addr = ADDR_DBH;
                    drv_data = DIVISOR[15:8];
                end
                RX_RD: begin
                    bus_cs   = 1'b1;
                    bus_rw   = 1'b1;
                    bus_addr = ADDR_BUF;
                end
                TX_WR: begin
                    bus_cs   = 1'b1;
                    bus_rw   = 1'b0;
                    bus_addr = ADDR_BUF;
                    drv_data = tx_byte_reg;
                end
                default: begin
                    bus_cs   = 1'b0;
                    bus_rw   = 1'b1;
                    bus_addr = ADDR_BUF;
                end
            endcase
        end
    end

    assign iocs       = bus_cs;
    assign iorw       = bus_rw;
    assign ioaddr     = bus_addr;
    assign databus    = (bus_cs && !bus_rw) ? drv_data : 8'hzz;
    assign io_ready   = io_ready_reg;
    assign io_rd_data = io_rd_data_reg;

endmodule

// File: tb/tb_spart_bus_ctrl.sv
// Scoreboard bench for spart_bus_ctrl: host requests queue their expected response,
// a negedge monitor compares every io_ready pulse and every SPART TX write.
module tb_spart_bus_ctrl;

    logic        clk;
    logic        rst;
    logic        io_valid;
    logic        io_rw;
    logic [27:0] mem_addr;
    logic [31:0] io_wr_data;
    logic        io_ready;
    logic [31:0] io_rd_data;
    logic        iocs;
    logic        iorw;
    logic [1:0]  ioaddr;
    wire  [7:0]  databus;
    logic        rda;
    logic        tbr;
    logic [7:0]  spart_byte;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ready_cnt = 0;
    int rx_cnt = 0;
    int rx_cyc = 0;
    int tx_cyc = 0;

    logic [31:0] exp_q[$];
    logic [7:0]  tx_exp_q[$];
    logic [31:0] exp_word;
    logic [7:0]  tx_word;

    localparam logic [27:0] BASE = 28'h800_0000;

    spart_bus_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .io_valid   (io_valid),
        .io_rw      (io_rw),
        .mem_addr   (mem_addr),
        .io_wr_data (io_wr_data),
        .io_ready   (io_ready),
        .io_rd_data (io_rd_data),
        .iocs       (iocs),
        .iorw       (iorw),
        .ioaddr     (ioaddr),
        .databus    (databus),
        .rda        (rda),
        .tbr        (tbr)
    );

    assign databus = (iocs && iorw) ? spart_byte : 8'hzz;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && io_ready) begin
            ready_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ready: got io_rd_data=%h expected no response", io_rd_data);
            end else begin
                exp_word = exp_q.pop_front();
                check("resp", io_rd_data, exp_word);
            end
        end
        if (!rst && iocs && !iorw && ioaddr == 2'b00) begin
            tx_cyc = cyc;
            check("tx_tbr", {31'h0, tbr}, 32'h1);
            if (tx_exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_tx: got databus=%h expected no write", databus);
            end else begin
                tx_word = tx_exp_q.pop_front();
                check("tx_byte", {24'h0, databus}, {24'h0, tx_word});
            end
        end
        if (!rst && iocs && iorw) begin
            rx_cnt++;
            rx_cyc = cyc;
        end
    end

    task automatic host(input logic rw, input logic [27:0] a, input logic [31:0] wd,
                        input logic [31:0] exp);
        int n;
        exp_q.push_back(exp);
        if (rw && a == BASE) tx_exp_q.push_back(wd[7:0]);
        @(posedge clk);
        #1;
        io_valid = 1'b1;
        io_rw = rw;
        mem_addr = a;
        io_wr_data = wd;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!io_ready && n < 200);
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL host_timeout: got no io_ready expected pulse within 200 cycles");
        end
        @(posedge clk);
        #1;
        io_valid = 1'b0;
    endtask

    task automatic rx_byte(input logic [7:0] b);
        int n;
        @(posedge clk);
        #1;
        spart_byte = b;
        rda = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(iocs && iorw) && n < 200);
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL rx_timeout: got no RX read expected one within 200 cycles");
        end
        @(posedge clk);
        #1;
        rda = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        @(negedge clk);
        check({tag, "_iocs"}, {31'h0, iocs}, 32'h0);
        check({tag, "_iorw"}, {31'h0, iorw}, 32'h1);
        check({tag, "_ioaddr"}, {30'h0, ioaddr}, 32'h0);
        check({tag, "_io_ready"}, {31'h0, io_ready}, 32'h0);
        check({tag, "_io_rd_data"}, io_rd_data, 32'h0);
    endtask

    task automatic check_cfg(input string tag);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check({tag, "_c1_bus"}, {28'h0, iocs, iorw, ioaddr}, {28'h0, 1'b1, 1'b0, 2'b10});
        check({tag, "_c1_data"}, {24'h0, databus}, 32'h8A);
        @(negedge clk);
        check({tag, "_c2_bus"}, {28'h0, iocs, iorw, ioaddr}, {28'h0, 1'b1, 1'b0, 2'b11});
        check({tag, "_c2_data"}, {24'h0, databus}, 32'h02);
        @(negedge clk);
        check({tag, "_c3_iocs"}, {31'h0, iocs}, 32'h0);
    endtask

    initial begin
        int rx_before;
        int ready_before;
        rst = 1'b1;
        io_valid = 1'b0;
        io_rw = 1'b0;
        mem_addr = '0;
        io_wr_data = '0;
        rda = 1'b0;
        tbr = 1'b1;
        spart_byte = 8'h00;
        repeat (2) @(posedge clk);
        check_reset_outputs("reset");
        check_cfg("cfg");

        // TX held off by tbr=0 for five cycles
        tbr = 1'b0;
        fork
            host(1'b1, BASE, 32'h0000_0041, 32'h0);
            begin
                repeat (5) @(posedge clk);
                #1;
                tbr = 1'b1;
            end
        join

        // single RX byte, then status and data reads
        rx_before = rx_cnt;
        rx_byte(8'h5A);
        check("rx_one_cycle", rx_cnt - rx_before, 32'd1);
        host(1'b0, BASE + 28'd1, 32'h0, 32'h0000_0013);
        host(1'b0, BASE, 32'h0, 32'h0000_005A);
        host(1'b0, BASE + 28'd1, 32'h0, 32'h0000_0002);

        // overflow: five bytes into four entries
        for (int i = 1; i <= 5; i++) rx_byte(8'(i));
        host(1'b0, BASE + 28'd1, 32'h0, 32'h0000_0047);
        host(1'b0, BASE + 28'd1, 32'h0, 32'h0000_0043);
        for (int i = 1; i <= 4; i++) host(1'b0, BASE, 32'h0, 32'(i));
        host(1'b0, BASE, 32'h0, 32'h0);
        host(1'b1, BASE + 28'd1, 32'h0000_00FF, 32'h0);
        host(1'b0, 28'h123_4567, 32'h0, 32'h0);

        // RX preempts a TX waiting for tbr
        tbr = 1'b0;
        fork
            host(1'b1, BASE, 32'h0000_0077, 32'h0);
            begin
                repeat (3) @(posedge clk);
                rx_byte(8'hC3);
                repeat (2) @(posedge clk);
                #1;
                tbr = 1'b1;
            end
        join
        check("rx_before_tx", {31'h0, rx_cyc < tx_cyc}, 32'h1);
        host(1'b0, BASE, 32'h0, 32'h0000_00C3);

        // reset while a TX is parked in TX_WAIT
        tbr = 1'b0;
        ready_before = ready_cnt;
        @(posedge clk);
        #1;
        io_valid = 1'b1;
        io_rw = 1'b1;
        mem_addr = BASE;
        io_wr_data = 32'h0000_0099;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        io_valid = 1'b0;
        check_reset_outputs("midrst");
        check_cfg("recfg");
        check("midrst_no_ready", ready_cnt - ready_before, 32'd0);
        tbr = 1'b1;
        host(1'b0, BASE + 28'd1, 32'h0, 32'h0000_0002);

        repeat (4) @(negedge clk);
        check("resp_queue_drained", exp_q.size(), 32'd0);
        check("tx_queue_drained", tx_exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected end within 2 ms");
        $fatal(1, "watchdog expired");
    end

endmodule
